// File: rtl/bus_addr_decoder.sv
`default_nettype none
// ============================================================================
// Module  : bus_addr_decoder
// Brief   : CPU data-bus address decoder with active-low chip selects,
//           registered data-phase select and unmapped-access error capture.
// Revision: 1.0 - initial release
// ============================================================================
module bus_addr_decoder #(
  parameter logic [31:0] DMEM_BASE  = 32'h1000_0000,
  parameter int          DMEM_AW    = 14,
  parameter logic [31:0] TBMAN_BASE = 32'h8000_0000,
  parameter int          TBMAN_AW   = 8,
  parameter logic [31:0] GPIO_BASE  = 32'hFFFF_2000,
  parameter int          GPIO_AW    = 8,
  parameter logic [31:0] TIMER_BASE = 32'hFFFF_0000,
  parameter int          TIMER_AW   = 8,
  parameter int          ERRCNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         bus_addr,
  input  logic                bus_rd,
  input  logic                bus_wr,
  output logic                cs_dmem_n,
  output logic                cs_tbman_n,
  output logic                cs_gpio_n,
  output logic                cs_timer_n,
  output logic [2:0]          dphase_sel,
  output logic                dphase_rd,
  output logic                err_flag,
  output logic [31:0]         err_addr,
  output logic                err_we,
  output logic [ERRCNT_W-1:0] err_cnt,
  input  logic                err_clr
);

  localparam logic [2:0] c_SEL_NONE  = 3'd0;
  localparam logic [2:0] c_SEL_TBMAN = 3'd1;
  localparam logic [2:0] c_SEL_DMEM  = 3'd2;
  localparam logic [2:0] c_SEL_GPIO  = 3'd3;
  localparam logic [2:0] c_SEL_TIMER = 3'd4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ERR  = 1'b1
  } err_state_t;

  err_state_t r_state;
  err_state_t w_state_next;

  logic       w_req;
  logic       w_hit_dmem;
  logic       w_hit_tbman;
  logic       w_hit_gpio;
  logic       w_hit_timer;
  logic       w_any_hit;
  logic       w_win_tbman;
  logic       w_win_dmem;
  logic       w_win_gpio;
  logic       w_win_timer;
  logic       w_fault;
  logic       w_cnt_max;
  logic [2:0] w_sel;

  logic [2:0]          r_dphase_sel;
  logic                r_dphase_rd;
  logic [31:0]         r_err_addr;
  logic                r_err_we;
  logic [ERRCNT_W-1:0] r_err_cnt;

  assign w_req       = bus_rd | bus_wr;
  assign w_hit_dmem  = (bus_addr >> DMEM_AW)  == (DMEM_BASE  >> DMEM_AW);
  assign w_hit_tbman = (bus_addr >> TBMAN_AW) == (TBMAN_BASE >> TBMAN_AW);
  assign w_hit_gpio  = (bus_addr >> GPIO_AW)  == (GPIO_BASE  >> GPIO_AW);
  assign w_hit_timer = (bus_addr >> TIMER_AW) == (TIMER_BASE >> TIMER_AW);
  assign w_any_hit   = w_hit_dmem | w_hit_tbman | w_hit_gpio | w_hit_timer;

  // Overlapping regions resolve TBMAN > DMEM > GPIO > TIMER, so one select at most.
  always_comb begin
    w_win_tbman = 1'b0;
    w_win_dmem  = 1'b0;
    w_win_gpio  = 1'b0;
    w_win_timer = 1'b0;
    w_sel       = c_SEL_NONE;
    if (w_req == 1'b1) begin
      if (w_hit_tbman) begin
        w_win_tbman = 1'b1;
        w_sel       = c_SEL_TBMAN;
      end else if (w_hit_dmem) begin
        w_win_dmem  = 1'b1;
        w_sel       = c_SEL_DMEM;
      end else if (w_hit_gpio) begin
        w_win_gpio  = 1'b1;
        w_sel       = c_SEL_GPIO;
      end else if (w_hit_timer) begin
        w_win_timer = 1'b1;
        w_sel       = c_SEL_TIMER;
      end
    end
  end

  assign cs_tbman_n = ~(w_win_tbman & ~reset);
  assign cs_dmem_n  = ~(w_win_dmem  & ~reset);
  assign cs_gpio_n  = ~(w_win_gpio  & ~reset);
  assign cs_timer_n = ~(w_win_timer & ~reset);

  assign w_fault   = w_req & ~w_any_hit;
  assign w_cnt_max = &r_err_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dphase_sel <= c_SEL_NONE;
      r_dphase_rd  <= 1'b0;
    end else begin
      r_dphase_sel <= w_sel;
      r_dphase_rd  <= bus_rd & w_any_hit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A clear in the same cycle as a fault wins; that fault is dropped.
  always_comb begin
    w_state_next = r_state;
    if (err_clr) begin
      w_state_next = ST_IDLE;
    end else if (w_fault) begin
      w_state_next = ST_ERR;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_addr <= 32'd0;
      r_err_we   <= 1'b0;
      r_err_cnt  <= '0;
    end else if (err_clr) begin
      r_err_addr <= 32'd0;
      r_err_we   <= 1'b0;
      r_err_cnt  <= '0;
    end else if (w_fault) begin
      if (r_state == ST_IDLE) begin
        r_err_addr <= bus_addr;
        r_err_we   <= bus_wr;
        r_err_cnt  <= ERRCNT_W'(1);
      end else if (!w_cnt_max) begin
        r_err_cnt  <= r_err_cnt + ERRCNT_W'(1);
      end
    end
  end

  assign dphase_sel = r_dphase_sel;
  assign dphase_rd  = r_dphase_rd;
  assign err_flag   = (r_state == ST_ERR);
  assign err_addr   = r_err_addr;
  assign err_we     = r_err_we;
  assign err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bus_addr_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_addr_decoder
// Brief   : Directed plus randomized bench for bus_addr_decoder against a
//           range-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bus_addr_decoder;

  localparam logic [31:0] c_DMEM_BASE  = 32'h1000_0000;
  localparam int          c_DMEM_AW    = 14;
  localparam logic [31:0] c_TBMAN_BASE = 32'h8000_0000;
  localparam int          c_TBMAN_AW   = 8;
  localparam logic [31:0] c_GPIO_BASE  = 32'hFFFF_2000;
  localparam int          c_GPIO_AW    = 8;
  localparam logic [31:0] c_TIMER_BASE = 32'hFFFF_0000;
  localparam int          c_TIMER_AW   = 8;
  localparam int          c_ERRCNT_W   = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic        cs_dmem_n;
  logic        cs_tbman_n;
  logic        cs_gpio_n;
  logic        cs_timer_n;
  logic [2:0]  dphase_sel;
  logic        dphase_rd;
  logic        err_flag;
  logic [31:0] err_addr;
  logic        err_we;
  logic [c_ERRCNT_W-1:0] err_cnt;
  logic        err_clr;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          m_sel;
  bit          m_rd;
  bit          m_flag;
  logic [31:0] m_addr;
  bit          m_we;
  int          m_cnt;

  bus_addr_decoder #(
    .DMEM_BASE (c_DMEM_BASE),  .DMEM_AW (c_DMEM_AW),
    .TBMAN_BASE(c_TBMAN_BASE), .TBMAN_AW(c_TBMAN_AW),
    .GPIO_BASE (c_GPIO_BASE),  .GPIO_AW (c_GPIO_AW),
    .TIMER_BASE(c_TIMER_BASE), .TIMER_AW(c_TIMER_AW),
    .ERRCNT_W  (c_ERRCNT_W)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .bus_addr  (bus_addr),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .cs_dmem_n (cs_dmem_n),
    .cs_tbman_n(cs_tbman_n),
    .cs_gpio_n (cs_gpio_n),
    .cs_timer_n(cs_timer_n),
    .dphase_sel(dphase_sel),
    .dphase_rd (dphase_rd),
    .err_flag  (err_flag),
    .err_addr  (err_addr),
    .err_we    (err_we),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rgn(input logic [31:0] a, input logic [31:0] base, input int aw);
    longint unsigned lo, hi;
    lo = longint'(base);
    hi = lo + (64'd1 << aw);
    return (longint'(a) >= lo) && (longint'(a) < hi);
  endfunction

  function automatic int ref_sel(input logic [31:0] a, input bit req);
    if (!req) return 0;
    if (in_rgn(a, c_TBMAN_BASE, c_TBMAN_AW)) return 1;
    if (in_rgn(a, c_DMEM_BASE,  c_DMEM_AW))  return 2;
    if (in_rgn(a, c_GPIO_BASE,  c_GPIO_AW))  return 3;
    if (in_rgn(a, c_TIMER_BASE, c_TIMER_AW)) return 4;
    return 0;
  endfunction

  task automatic model_reset();
    m_sel = 0; m_rd = 0; m_flag = 0; m_addr = 32'd0; m_we = 0; m_cnt = 0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".dphase_sel"}, 32'(dphase_sel), 32'(m_sel));
    chk({tag, ".dphase_rd"},  32'(dphase_rd),  32'(m_rd));
    chk({tag, ".err_flag"},   32'(err_flag),   32'(m_flag));
    chk({tag, ".err_addr"},   err_addr,        m_addr);
    chk({tag, ".err_we"},     32'(err_we),     32'(m_we));
    chk({tag, ".err_cnt"},    32'(err_cnt),    32'(m_cnt));
  endtask

  // Entered just after a rising edge; drives one bus cycle and checks both phases.
  task automatic run_cycle(input string tag, input logic [31:0] a,
                           input bit rd, input bit wr, input bit clr);
    int s;
    bit req;
    bus_addr = a; bus_rd = rd; bus_wr = wr; err_clr = clr;
    req = rd | wr;
    s = ref_sel(a, req);
    #3;
    chk({tag, ".cs_tbman_n"}, 32'(cs_tbman_n), 32'(s != 1));
    chk({tag, ".cs_dmem_n"},  32'(cs_dmem_n),  32'(s != 2));
    chk({tag, ".cs_gpio_n"},  32'(cs_gpio_n),  32'(s != 3));
    chk({tag, ".cs_timer_n"}, 32'(cs_timer_n), 32'(s != 4));
    m_sel = s;
    m_rd  = rd && (s != 0);
    if (clr) begin
      m_flag = 0; m_addr = 32'd0; m_we = 0; m_cnt = 0;
    end else if (req && s == 0) begin
      if (!m_flag) begin
        m_flag = 1; m_addr = a; m_we = wr; m_cnt = 1;
      end else if (m_cnt < (1 << c_ERRCNT_W) - 1) begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    chk_regs(tag);
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] b;
    int aw;
    case ($urandom_range(0, 5))
      0: begin b = c_DMEM_BASE;  aw = c_DMEM_AW;  end
      1: begin b = c_TBMAN_BASE; aw = c_TBMAN_AW; end
      2: begin b = c_GPIO_BASE;  aw = c_GPIO_AW;  end
      3: begin b = c_TIMER_BASE; aw = c_TIMER_AW; end
      4: return $urandom();
      default: begin
        b = ($urandom_range(0, 1) == 0) ? c_DMEM_BASE : c_GPIO_BASE;
        aw = (b == c_DMEM_BASE) ? c_DMEM_AW : c_GPIO_AW;
        return ($urandom_range(0, 1) == 0) ? b - 32'd1 : b + 32'(1 << aw);
      end
    endcase
    return b + 32'($urandom_range(0, (1 << aw) - 1));
  endfunction

  initial begin
    reset = 1'b1; bus_addr = 32'h1000_0010; bus_rd = 1'b1; bus_wr = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.cs_tbman_n", 32'(cs_tbman_n), 32'd1);
    chk("rst.cs_dmem_n",  32'(cs_dmem_n),  32'd1);
    chk("rst.cs_gpio_n",  32'(cs_gpio_n),  32'd1);
    chk("rst.cs_timer_n", 32'(cs_timer_n), 32'd1);
    chk_regs("rst");
    reset = 1'b0;
    run_cycle("rel_dmem", 32'h1000_0010, 1, 0, 0);

    run_cycle("b2b_tbman", 32'h8000_0004, 1, 0, 0);
    run_cycle("b2b_gpio",  32'hFFFF_2008, 1, 0, 0);
    run_cycle("b2b_timer", 32'hFFFF_0000, 1, 0, 0);

    run_cycle("dmem_top",  32'h1000_3FFC, 0, 1, 0);
    run_cycle("noreq",     32'h1000_0000, 0, 0, 0);
    run_cycle("fault1",    32'h2000_0000, 0, 1, 0);
    run_cycle("fault2",    32'h3000_0000, 1, 0, 0);
    for (int i = 0; i < 300; i++)
      run_cycle("fault_sat", 32'h2000_1000 + 32'(i * 4), 1, (i % 2) == 1, 0);
    run_cycle("clr_fault", 32'h4000_0000, 0, 1, 1);
    run_cycle("after_clr", 32'h5000_0000, 1, 1, 0);
    run_cycle("dmem_end",  32'h1000_4000, 1, 0, 0);
    run_cycle("clr_idle",  32'h1000_4000, 0, 0, 1);
    run_cycle("clr_idle2", 32'h0000_0000, 0, 0, 1);
    run_cycle("tbman_lo",  32'h7FFF_FFFF, 1, 0, 0);

    // Reset in the middle of an access drops the data phase immediately.
    run_cycle("pre_rst", 32'h8000_0010, 1, 0, 0);
    reset = 1'b1;
    #1;
    model_reset();
    chk("mid_rst.cs_tbman_n", 32'(cs_tbman_n), 32'd1);
    chk_regs("mid_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_cycle("post_rst", 32'hFFFF_20FF, 1, 0, 0);

    for (int i = 0; i < 250; i++)
      run_cycle("rand", pick_addr(), $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
